// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the UART-driven RGB status LED command decoder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: ASCII command bytes, the error response byte, the LED operation
// enum and the 3-bit channel mask type (bit 0 = red, 1 = green, 2 = blue).
package led_ctrl_pkg;

    localparam logic [7:0] CMD_R_ON    = 8'h52;  // 'R'
    localparam logic [7:0] CMD_R_OFF   = 8'h72;  // 'r'
    localparam logic [7:0] CMD_G_ON    = 8'h47;  // 'G'
    localparam logic [7:0] CMD_G_OFF   = 8'h67;  // 'g'
    localparam logic [7:0] CMD_B_ON    = 8'h42;  // 'B'
    localparam logic [7:0] CMD_B_OFF   = 8'h62;  // 'b'
    localparam logic [7:0] CMD_ALL_ON  = 8'h57;  // 'W'
    localparam logic [7:0] CMD_ALL_OFF = 8'h58;  // 'X'
    localparam logic [7:0] RESP_ERR    = 8'h3F;  // '?'

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_SET  = 2'd1,
        OP_CLR  = 2'd2
    } op_t;

    typedef logic [2:0] chan_mask_t;

    localparam chan_mask_t CH_R   = 3'b001;
    localparam chan_mask_t CH_G   = 3'b010;
    localparam chan_mask_t CH_B   = 3'b100;
    localparam chan_mask_t CH_ALL = 3'b111;

endpackage

// File: rtl/led_cmd_decode.sv
// Combinational ASCII command decoder: byte -> (op, channel mask, valid).
// Latency: 0 cycles (purely combinational).
// Backpressure: none; output follows input every cycle.
//
// Ports:
//   cmd_byte  in   8  candidate command byte
//   op        out  2  OP_SET / OP_CLR, OP_NONE for unknown bytes
//   mask      out  3  channels addressed by the command
//   valid     out  1  byte is one of the eight known commands
module led_cmd_decode
    import led_ctrl_pkg::*;
(
    input  logic [7:0] cmd_byte,
    output op_t        op,
    output chan_mask_t mask,
    output logic       valid
);

    always_comb begin
        op    = OP_NONE;
        mask  = '0;
        valid = 1'b0;
        case (cmd_byte)
            CMD_R_ON:    begin op = OP_SET; mask = CH_R;   valid = 1'b1; end
            CMD_R_OFF:   begin op = OP_CLR; mask = CH_R;   valid = 1'b1; end
            CMD_G_ON:    begin op = OP_SET; mask = CH_G;   valid = 1'b1; end
            CMD_G_OFF:   begin op = OP_CLR; mask = CH_G;   valid = 1'b1; end
            CMD_B_ON:    begin op = OP_SET; mask = CH_B;   valid = 1'b1; end
            CMD_B_OFF:   begin op = OP_CLR; mask = CH_B;   valid = 1'b1; end
            CMD_ALL_ON:  begin op = OP_SET; mask = CH_ALL; valid = 1'b1; end
            CMD_ALL_OFF: begin op = OP_CLR; mask = CH_ALL; valid = 1'b1; end
            default:     ;
        endcase
    end

endmodule

// File: rtl/led_controller.sv
// UART command byte -> registered RGB LED states, with error pulse and optional echo.
// Latency: LED/cmd_err update at the edge sampling rx_done; echo tx_start at that same edge if tx_busy=0.
// Backpressure: none on rx (every strobe is consumed); echo waits on tx_busy, latest response wins.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   rx_byte, rx_done    command byte and its one-cycle valid strobe
//   led_r/g/b           LED pins, inverted when ACTIVE_LOW=1
//   cmd_err             one-cycle pulse after an unknown byte
//   tx_byte, tx_start, tx_busy   echo path, present only with LED_CTRL_ECHO_EN
module led_controller
    import led_ctrl_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_byte,
    input  logic       rx_done,
    output logic       led_r,
    output logic       led_g,
    output logic       led_b,
    output logic       cmd_err
`ifdef LED_CTRL_ECHO_EN
    ,
    output logic [7:0] tx_byte,
    output logic       tx_start,
    input  logic       tx_busy
`endif
);

    op_t        dec_op;
    chan_mask_t dec_mask;
    logic       dec_valid;
    chan_mask_t led_state;

    led_cmd_decode u_decode (
        .cmd_byte (rx_byte),
        .op       (dec_op),
        .mask     (dec_mask),
        .valid    (dec_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_state <= '0;
            cmd_err   <= 1'b0;
        end else begin
            cmd_err <= rx_done && !dec_valid;
            if (rx_done && dec_valid) begin
                case (dec_op)
                    OP_SET:  led_state <= led_state | dec_mask;
                    OP_CLR:  led_state <= led_state & ~dec_mask;
                    default: ;
                endcase
            end
        end
    end

    // Polarity is applied after the state register so internal state stays "1 = on".
    assign led_r = led_state[0] ^ ACTIVE_LOW;
    assign led_g = led_state[1] ^ ACTIVE_LOW;
    assign led_b = led_state[2] ^ ACTIVE_LOW;

`ifdef LED_CTRL_ECHO_EN
    logic [7:0] resp_byte;
    logic       pend_vld;
    logic [7:0] pend_dat;

    assign resp_byte = dec_valid ? rx_byte : RESP_ERR;

    // A fresh strobe always takes priority over an older pending response,
    // so a response waiting on tx_busy is simply overwritten.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_byte  <= '0;
            tx_start <= 1'b0;
            pend_vld <= 1'b0;
            pend_dat <= '0;
        end else begin
            tx_start <= 1'b0;
            if (rx_done) begin
                if (!tx_busy) begin
                    tx_start <= 1'b1;
                    tx_byte  <= resp_byte;
                    pend_vld <= 1'b0;
                end else begin
                    pend_vld <= 1'b1;
                    pend_dat <= resp_byte;
                end
            end else if (pend_vld && !tx_busy) begin
                tx_start <= 1'b1;
                tx_byte  <= pend_dat;
                pend_vld <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_led_controller.sv
// Self-checking bench for led_controller: directed steps then random bytes against a reference model.
module tb_led_controller;

    localparam bit AL = 1'b0;

    logic       clk;
    logic       rst;
    logic [7:0] rx_byte;
    logic       rx_done;
    logic       led_r, led_g, led_b, cmd_err;
`ifdef LED_CTRL_ECHO_EN
    logic [7:0] tx_byte;
    logic       tx_start;
    logic       tx_busy;
`endif

    led_controller #(.ACTIVE_LOW(AL)) dut (
        .clk     (clk),
        .rst     (rst),
        .rx_byte (rx_byte),
        .rx_done (rx_done),
        .led_r   (led_r),
        .led_g   (led_g),
        .led_b   (led_b),
        .cmd_err (cmd_err)
`ifdef LED_CTRL_ECHO_EN
        ,
        .tx_byte (tx_byte),
        .tx_start(tx_start),
        .tx_busy (tx_busy)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: LED on/off flags indexed 0=red 1=green 2=blue.
    bit       m_on [3];
    bit       m_err;
    bit       m_tx_start;
    bit [7:0] m_tx_byte;
    bit       tx_auto;

    byte unsigned cmd_list [8] = '{8'h52, 8'h72, 8'h47, 8'h67, 8'h42, 8'h62, 8'h57, 8'h58};

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Applies one strobed byte to the model: upper-case letter turns channels on,
    // lower-case turns them off, 'W'/'X' address all three.
    function automatic bit model_apply(input byte unsigned b);
        int ch;
        bit on;
        ch = -1;
        on = 1'b0;
        case (b)
            "R": begin ch = 0; on = 1; end
            "r": begin ch = 0; on = 0; end
            "G": begin ch = 1; on = 1; end
            "g": begin ch = 1; on = 0; end
            "B": begin ch = 2; on = 1; end
            "b": begin ch = 2; on = 0; end
            "W": begin ch = 3; on = 1; end
            "X": begin ch = 3; on = 0; end
            default: return 1'b0;
        endcase
        if (ch == 3) foreach (m_on[i]) m_on[i] = on;
        else         m_on[ch] = on;
        return 1'b1;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".led_r"},   led_r,   8'(m_on[0] ^ AL));
        check({tag, ".led_g"},   led_g,   8'(m_on[1] ^ AL));
        check({tag, ".led_b"},   led_b,   8'(m_on[2] ^ AL));
        check({tag, ".cmd_err"}, cmd_err, 8'(m_err));
`ifdef LED_CTRL_ECHO_EN
        if (tx_auto) begin
            check({tag, ".tx_start"}, tx_start, 8'(m_tx_start));
            check({tag, ".tx_byte"},  tx_byte,  m_tx_byte);
        end
`endif
    endtask

    // Drive one cycle's inputs (called #1 after a rising edge), advance one edge, check.
    task automatic step(input string tag, input logic [7:0] b, input logic d);
        bit ok;
        rx_byte = b;
        rx_done = d;
        @(posedge clk);
        #1;
        rx_done = 1'b0;
        ok = 1'b0;
        if (d) ok = model_apply(b);
        m_err      = d && !ok;
        m_tx_start = d;
        if (d) m_tx_byte = ok ? b : 8'h3F;
        check_all(tag);
    endtask

    initial begin
        rst        = 1'b1;
        rx_byte    = 8'h00;
        rx_done    = 1'b0;
        tx_auto    = 1'b1;
        m_err      = 1'b0;
        m_tx_start = 1'b0;
        m_tx_byte  = 8'h00;
        foreach (m_on[i]) m_on[i] = 1'b0;
`ifdef LED_CTRL_ECHO_EN
        tx_busy = 1'b0;
`endif
        #2;
        check_all("reset");
        #20;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single-channel walk and all-on / all-off.
        step("R_on",  "R", 1'b1);
        step("r_off", "r", 1'b1);
        step("G_on",  "G", 1'b1);
        step("g_off", "g", 1'b1);
        step("B_on",  "B", 1'b1);
        step("b_off", "b", 1'b1);
        step("W_all", "W", 1'b1);
        step("W_rep", "W", 1'b1);
        step("X_all", "X", 1'b1);

        // Unknown byte with red on: red holds, error pulse lasts one cycle.
        step("R_on2",  "R",   1'b1);
        step("bad41",  8'h41, 1'b1);
        step("err_end", 8'h41, 1'b0);

        // rx_byte ignored without strobe.
        repeat (5) step("no_strobe", "G", 1'b0);

        // Back-to-back strobes are separate commands.
        step("bb_G", "G", 1'b1);
        step("bb_B", "B", 1'b1);

        // Asynchronous reset mid-stream: outputs clear before the next edge.
        rst = 1'b1;
        #1;
        foreach (m_on[i]) m_on[i] = 1'b0;
        m_err      = 1'b0;
        m_tx_start = 1'b0;
        m_tx_byte  = 8'h00;
        check_all("async_rst");
        // A strobe seen while reset is still asserted is dropped.
        rx_byte = "W";
        rx_done = 1'b1;
        @(posedge clk);
        #1;
        rx_done = 1'b0;
        check_all("strobe_in_rst");
        rst = 1'b0;
        step("after_rst", "R", 1'b1);

`ifdef LED_CTRL_ECHO_EN
        // Echo held off while the transmitter is busy, then exactly one pulse.
        tx_auto = 1'b0;
        tx_busy = 1'b1;
        step("echo_busy0", "B", 1'b1);
        check("echo_hold0", tx_start, 8'h00);
        step("echo_busy1", "B", 1'b0);
        check("echo_hold1", tx_start, 8'h00);
        step("echo_busy2", "B", 1'b0);
        check("echo_hold2", tx_start, 8'h00);
        tx_busy = 1'b0;
        step("echo_rel", 8'h00, 1'b0);
        check("echo_pulse", tx_start, 8'h01);
        check("echo_byte",  tx_byte,  8'h42);
        step("echo_once", 8'h00, 1'b0);
        check("echo_single", tx_start, 8'h00);
        check("echo_stable", tx_byte,  8'h42);
        tx_auto = 1'b1;
        step("echo_err", 8'h00, 1'b1);
        check("echo_err_byte", tx_byte, 8'h3F);
`endif

        // Random mix of valid commands, garbage bytes and idle cycles.
        for (int n = 0; n < 400; n++) begin
            logic [7:0] b;
            logic       d;
            d = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) b = cmd_list[$urandom_range(0, 7)];
            else                           b = 8'($urandom);
            step("rand", b, d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
